// File: rtl/mem_fifo_ctrl_if.sv
// Bundle of stream, register-file and status signals around mem_fifo_ctrl.
// master = the controller, slave = the surrounding environment.
interface mem_fifo_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       mem_we;
  logic [2:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       last_grant;  // arbiter state, 0 = write won last, 1 = read won last

  modport master (
    input  in_valid, in_data, out_ready, mem_dout,
    output in_ready, out_valid, out_data, mem_we, mem_addr, mem_din,
           count, full, empty, last_grant
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_dout,
    input  in_ready, out_valid, out_data, mem_we, mem_addr, mem_din,
           count, full, empty, last_grant
  );
endinterface

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller owning the single address port of an 8x8 register file,
// with a one-entry output register; 9 bytes total capacity.
module mem_fifo_ctrl (
  input  logic           clk,
  input  logic           rst,
  mem_fifo_ctrl_if.master bus
);
  // Handshakes: a byte moves on a side exactly in a cycle where valid && ready
  // are both high at the rising edge; ready never depends on valid on the same
  // side, and a producer holds data stable until it is taken.

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

  grant_t     grant_q, grant_d;
  logic [2:0] wr_ptr, rd_ptr;
  logic [3:0] count_q;
  logic       out_valid_q;
  logic [7:0] out_data_q;

  logic       full_w, empty_w;
  logic       rd_req, in_ready_w, wr_g, rd_g;

  assign full_w  = (count_q == 4'd8);
  assign empty_w = (count_q == 4'd0);

  // Arbitration: when a write and a read both want the port, the side that
  // did not win last time gets it.
  always_comb begin
    rd_req       = 1'b0;
    in_ready_w   = 1'b0;
    wr_g         = 1'b0;
    rd_g         = 1'b0;
    grant_d      = grant_q;
    bus.mem_we   = 1'b0;
    bus.mem_addr = rd_ptr;

    rd_req     = !empty_w && (!out_valid_q || bus.out_ready);
    in_ready_w = !full_w && !(rd_req && grant_q == GRANT_WR);
    wr_g       = bus.in_valid && in_ready_w;
    rd_g       = rd_req && !wr_g;

    if (wr_g) begin
      bus.mem_we   = 1'b1;
      bus.mem_addr = wr_ptr;
      grant_d      = GRANT_WR;
    end else if (rd_g) begin
      grant_d      = GRANT_RD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= GRANT_WR;
    end else begin
      grant_q <= grant_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= 3'd0;
      rd_ptr      <= 3'd0;
      count_q     <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      if (wr_g) begin
        wr_ptr <= wr_ptr + 3'd1;
      end
      if (rd_g) begin
        rd_ptr      <= rd_ptr + 3'd1;
        out_data_q  <= bus.mem_dout;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      // wr_g and rd_g are exclusive, so count moves by at most one.
      if (wr_g) begin
        count_q <= count_q + 4'd1;
      end else if (rd_g) begin
        count_q <= count_q - 4'd1;
      end
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.mem_din    = bus.in_data;
  assign bus.count      = count_q;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.last_grant = grant_q;

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Directed bench for mem_fifo_ctrl with a register-file model and an
// in-order scoreboard of accepted bytes.
module tb_mem_fifo_ctrl;
  logic clk;
  logic rst;

  mem_fifo_ctrl_if bus ();

  mem_fifo_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file: synchronous write, combinational read.
  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
  end
  assign bus.mem_dout = mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int total;
  int bad;
  int n_out;
  int b2b_we;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [7:0] held;
    logic       held_v;
    logic       prev_we;
    logic [7:0] e;
    held    = 8'h00;
    held_v  = 1'b0;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v  = 1'b0;
        prev_we = 1'b0;
      end else begin
        if (held_v && bus.out_valid) check("hold_out_data", {24'd0, bus.out_data}, {24'd0, held});
        held_v = bus.out_valid && !bus.out_ready;
        held   = bus.out_data;
        if (bus.mem_we && prev_we) b2b_we++;
        prev_we = bus.mem_we;
        if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
        if (bus.out_valid && bus.out_ready) begin
          n_out++;
          total++;
          assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL out_unexpected: observed=%0h expected=none", bus.out_data);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data_order", {24'd0, bus.out_data}, {24'd0, e});
          end
        end
      end
    end
  endtask

  task automatic send_bytes(input int n, input logic [7:0] base, input logic [7:0] step,
                            input int budget, output int accepted, output int cycles);
    accepted = 0;
    cycles   = 0;
    while (accepted < n && cycles < budget) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + step * 8'(accepted);
      @(negedge clk);
      if (bus.in_ready) accepted++;
      @(posedge clk);
      #1;
      cycles++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    while (!(bus.empty && !bus.out_valid) && c < 40) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, {30'd0, bus.empty, bus.out_valid}, 32'd2);
    check({tag, "_queue"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int acc;
    int cyc;
    int n0;
    total = 0;
    bad   = 0;
    n_out = 0;
    b2b_we = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    fork
      monitor_loop();
    join_none

    // Reset values
    #2;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_count", bus.count, 0);
    check("rst_full", bus.full, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_last_grant", bus.last_grant, 0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Fill with out_ready low: exactly 9 bytes fit
    n0 = n_out;
    send_bytes(10, 8'h05, 8'h10, 20, acc, cyc);
    check("fill_accepted", acc, 9);
    check("fill_in_ready", bus.in_ready, 0);
    check("fill_full", bus.full, 1);
    check("fill_count", bus.count, 8);
    check("fill_out_valid", bus.out_valid, 1);
    check("fill_out_data", bus.out_data, 8'h05);
    drain("fill_drain");
    check("fill_out_count", n_out - n0, 9);

    // Single byte latency
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    check("single_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("single_count_n", bus.count, 1);
    check("single_valid_n", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("single_valid_n1", bus.out_valid, 1);
    check("single_data_n1", bus.out_data, 8'hA5);
    check("single_count_n1", bus.count, 0);
    drain("single_drain");

    // Continuous streaming, 20 bytes, pointers wrap twice
    n0 = n_out;
    b2b_we = 0;
    bus.out_ready = 1'b1;
    send_bytes(20, 8'h00, 8'h01, 60, acc, cyc);
    check("stream_accepted", acc, 20);
    check("stream_rate", cyc <= 40, 1);
    drain("stream_drain");
    check("stream_out_count", n_out - n0, 20);
    check("stream_no_b2b_write", b2b_we, 0);

    // Backpressure with out_ready toggling
    n0 = n_out;
    bus.out_ready = 1'b0;
    send_bytes(3, 8'h40, 8'h01, 20, acc, cyc);
    check("bp_accepted", acc, 3);
    check("bp_count", bus.count, 2);
    check("bp_out_data", bus.out_data, 8'h40);
    for (int i = 0; i < 12; i++) begin
      bus.out_ready = (i % 2) == 1;
      @(posedge clk);
      #1;
    end
    drain("bp_drain");
    check("bp_out_count", n_out - n0, 3);

    // Reset mid-stream
    bus.out_ready = 1'b0;
    send_bytes(6, 8'h60, 8'h01, 20, acc, cyc);
    check("mid_count_pre", bus.count, 5);
    check("mid_valid_pre", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_count", bus.count, 0);
    check("mid_empty", bus.empty, 1);
    check("mid_in_ready", bus.in_ready, 1);
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    n0 = n_out;
    bus.out_ready = 1'b1;
    send_bytes(1, 8'h3C, 8'h00, 10, acc, cyc);
    check("mid_accepted", acc, 1);
    drain("mid_drain");
    check("mid_out_count", n_out - n0, 1);

    // Full boundary
    n0 = n_out;
    bus.out_ready = 1'b0;
    send_bytes(10, 8'h70, 8'h01, 20, acc, cyc);
    check("fb_accepted", acc, 9);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h79;
    bus.out_ready = 1'b1;
    #1;
    check("fb_in_ready_full", bus.in_ready, 0);
    check("fb_mem_we_full", bus.mem_we, 0);
    check("fb_mem_addr_read", bus.mem_addr, 2);
    @(posedge clk);
    #1;
    check("fb_count_after_read", bus.count, 7);
    bus.out_ready = 1'b0;
    #1;
    check("fb_in_ready_next", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("fb_count_refill", bus.count, 8);
    check("fb_full_refill", bus.full, 1);
    drain("fb_drain");
    check("fb_out_count", n_out - n0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
